// File: rtl/cis_dvp_pattern_tx.sv
// DVP sensor-side transmitter: emits framed test patterns (PCLK/VSYNC/HREF/D) for loopback
// into the ISP capture path. Pixel rate is half of wb_clk_i; all bus outputs change as PCLK falls.
module cis_dvp_pattern_tx #(
    parameter int DATA_W   = 10,
    parameter int CNT_W    = 12,
    parameter int H_ACTIVE = 64,
    parameter int H_BLANK  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 2,
    parameter int V_ACTIVE = 48,
    parameter int V_FRONT  = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              enable_i,
    input  logic [1:0]        pattern_sel_i,
    output logic              cis_pclk_o,
    output logic              cis_vsync_o,
    output logic              cis_hsync_o,
    output logic [DATA_W-1:0] cis_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_cnt_o
);

    // state  | meaning
    // IDLE   | no frame in progress, bus held low
    // SYNC   | VSYNC lines at frame start
    // BACK   | blank lines between VSYNC and first active line
    // ACTIVE | active lines, HREF high for the first H_ACTIVE pixels of each
    // FRONT  | blank lines after the last active line
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BACK, S_ACTIVE, S_FRONT} state_t;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE + H_BLANK - 1);
    localparam logic [CNT_W-1:0] X_ACT  = CNT_W'(H_ACTIVE);

    function automatic state_t skip_empty(input state_t s);
        state_t r;
        r = s;
        if (r == S_SYNC   && V_SYNC   == 0) r = S_BACK;
        if (r == S_BACK   && V_BACK   == 0) r = S_ACTIVE;
        if (r == S_ACTIVE && V_ACTIVE == 0) r = S_FRONT;
        if (r == S_FRONT  && V_FRONT  == 0) r = S_IDLE;
        return r;
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            S_SYNC:   return S_BACK;
            S_BACK:   return S_ACTIVE;
            S_ACTIVE: return S_FRONT;
            default:  return S_IDLE;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] last_line(input state_t s);
        case (s)
            S_SYNC:   return CNT_W'(V_SYNC - 1);
            S_BACK:   return CNT_W'(V_BACK - 1);
            S_ACTIVE: return CNT_W'(V_ACTIVE - 1);
            S_FRONT:  return CNT_W'(V_FRONT - 1);
            default:  return '0;
        endcase
    endfunction

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              pclk_q;
    state_t            state_q, state_d, nxt;
    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              vsync_q, hsync_q, busy_q, done_q;
    logic [DATA_W-1:0] data_q, pix;
    logic              tick, start, frame_end, pix_active;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign tick = pclk_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        nxt       = S_IDLE;
        start     = 1'b0;
        frame_end = 1'b0;
        if (tick) begin
            if (state_q == S_IDLE) begin
                start = enable_i;
            end else if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == last_line(state_q)) begin
                    y_d     = '0;
                    nxt     = skip_empty(succ(state_q));
                    state_d = nxt;
                    if (nxt == S_IDLE) begin
                        frame_end = 1'b1;
                        cnt_d     = cnt_q + 16'd1;
                        start     = enable_i;
                    end
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
            if (start) begin
                state_d = skip_empty(S_SYNC);
                x_d     = '0;
                y_d     = '0;
                sel_d   = pattern_sel_i;
            end
        end
    end

    // Outputs are computed from the next position so they line up with it on the same tick.
    always_comb begin
        pix_active = (state_d == S_ACTIVE) && (x_d < X_ACT);
        case (sel_d)
            2'd0:    pix = DATA_W'(x_d);
            2'd1:    pix = DATA_W'(y_d);
            2'd2:    pix = {DATA_W{x_d[3] ^ y_d[3]}};
            default: pix = DATA_W'(cnt_d);
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q  <= 1'b0;
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pclk_q  <= ~pclk_q;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= frame_end;
            if (tick) begin
                vsync_q <= (state_d == S_SYNC);
                hsync_q <= pix_active;
                data_q  <= pix_active ? pix : '0;
                busy_q  <= (state_d != S_IDLE);
            end
        end
    end

    assign cis_pclk_o   = pclk_q;
    assign cis_vsync_o  = vsync_q;
    assign cis_hsync_o  = hsync_q;
    assign cis_data_o   = data_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cis_dvp_pattern_tx.sv
// Directed bench for cis_dvp_pattern_tx: a DVP receiver model sampling on PCLK rising
// checks per-frame line/pixel counts, pattern data, frame timing and control behaviour.
module tb_cis_dvp_pattern_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, enable16;
    logic [1:0]  sel, sel16;

    logic        pclk, vsync, hsync, busy, fdone;
    logic [9:0]  data;
    logic [15:0] fcnt;
    logic        pclk16, vsync16, hsync16, busy16, fdone16;
    logic [9:0]  data16;
    logic [15:0] fcnt16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cis_dvp_pattern_tx #(.DATA_W(10), .CNT_W(12), .H_ACTIVE(4), .H_BLANK(2),
                         .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(enable), .pattern_sel_i(sel),
        .cis_pclk_o(pclk), .cis_vsync_o(vsync), .cis_hsync_o(hsync), .cis_data_o(data),
        .busy_o(busy), .frame_done_o(fdone), .frame_cnt_o(fcnt));

    cis_dvp_pattern_tx #(.DATA_W(10), .CNT_W(12), .H_ACTIVE(16), .H_BLANK(2),
                         .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)) dut16 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(enable16), .pattern_sel_i(sel16),
        .cis_pclk_o(pclk16), .cis_vsync_o(vsync16), .cis_hsync_o(hsync16), .cis_data_o(data16),
        .busy_o(busy16), .frame_done_o(fdone16), .frame_cnt_o(fcnt16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver state for the wide-line instance: first active line captured.
    int         line16, x16;
    logic       prev16;
    logic [9:0] d16 [16];
    always @(negedge clk) begin
        if (vsync16) begin
            line16 = 0; x16 = 0; prev16 = 1'b0;
        end else if (pclk16) begin
            if (hsync16 && line16 == 0) begin
                if (x16 < 16) d16[x16] = data16;
                x16++;
            end else if (!hsync16 && prev16) begin
                line16++;
            end
            prev16 = hsync16;
        end
    end

    // Receiver results for the main instance.
    bit         started, done_seen;
    int         clks, vs_ticks, lines, busy_low, start_wait;
    int         lens [8];
    logic [9:0] pix [8][8];

    task automatic recv_frame(input int drop_line);
        logic prev_h;
        int   x;
        started = 0; done_seen = 0; clks = 0; vs_ticks = 0; lines = 0;
        busy_low = 0; start_wait = 0; prev_h = 1'b0; x = 0;
        for (int l = 0; l < 8; l++) lens[l] = 0;
        for (int n = 0; n < 400; n++) begin
            if (started) clks++;
            if (!started && vsync) started = 1;
            else if (!started) start_wait++;
            if (started && fdone && clks > 0) begin
                done_seen = 1;
                break;
            end
            if (started && pclk) begin
                if (drop_line >= 0 && lines >= drop_line) begin
                    enable = 1'b0;
                    sel    = 2'd0;
                end
                if (!busy) busy_low++;
                if (vsync) vs_ticks++;
                if (hsync) begin
                    if (!prev_h) begin lines++; x = 0; end
                    if (lines <= 8 && x < 8) pix[lines-1][x] = data;
                    x++;
                    if (lines <= 8) lens[lines-1] = x;
                end
                prev_h = hsync;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [9:0] exp_pix(input int s, input int x, input int y, input int fc);
        case (s)
            0:       return 10'(x);
            1:       return 10'(y);
            2:       return (((x ^ y) & 8) != 0) ? 10'h3FF : 10'h000;
            default: return 10'(fc);
        endcase
    endfunction

    task automatic check_frame(input int s, input int fc, input bit exp_idle);
        check("frame_done_seen", 32'(done_seen), 1);
        check("frame_clks", clks, 72);
        check("vsync_ticks", vs_ticks, 6);
        check("href_lines", lines, 3);
        for (int l = 0; l < 3; l++) begin
            check("line_len", lens[l], 4);
            for (int x = 0; x < 4; x++) check("pixel", 32'(pix[l][x]), 32'(exp_pix(s, x, l, fc)));
        end
        check("busy_low_in_frame", busy_low, 0);
        check("frame_cnt_at_done", 32'(fcnt), 32'(fc + 1));
        check("busy_at_done", 32'(busy), exp_idle ? 0 : 1);
    endtask

    initial begin
        int toggles, nonzero;
        logic last_pclk;
        rst_n = 1'b0; enable = 1'b0; enable16 = 1'b0; sel = 2'd0; sel16 = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {fcnt, data, vsync, hsync, busy, fdone, pclk}, 0);
        rst_n = 1'b1;

        // 1: idle after reset, PCLK running, everything else low
        toggles = 0; nonzero = 0; last_pclk = pclk;
        repeat (20) begin
            @(negedge clk);
            if (pclk !== last_pclk) toggles++;
            last_pclk = pclk;
            if ({fcnt, data, vsync, hsync, busy, fdone} != 0) nonzero++;
        end
        check("idle_nonzero_samples", nonzero, 0);
        check("pclk_toggling", 32'(toggles >= 15), 1);

        // 2: one h-ramp frame; wide instance starts a checker frame alongside
        enable = 1'b1; sel = 2'd0; enable16 = 1'b1; sel16 = 2'd2;
        recv_frame(0);
        enable16 = 1'b0;
        check("start_latency_ok", 32'(start_wait <= 3), 1);
        check_frame(0, 0, 1);
        check("vsync_after_stop", 32'(vsync), 0);
        nonzero = 0;
        repeat (10) begin
            @(negedge clk);
            if (vsync || busy || hsync) nonzero++;
        end
        check("stays_idle", nonzero, 0);

        // 4: checker on the 16-pixel line, first active line
        for (int n = 0; n < 400; n++) begin
            if (fdone16) break;
            @(negedge clk);
        end
        check("wide_frame_done", 32'(fdone16), 1);
        check("wide_line0_len", x16, 16);
        for (int x = 0; x < 16; x++) check("wide_checker", 32'(d16[x]), (x >= 8) ? 32'h3FF : 32'h0);
        check("wide_frame_cnt", 32'(fcnt16), 1);
        check("wide_busy_after", 32'(busy16), 0);

        // 3 + 5: fresh reset, three back-to-back frame-number frames; enable drops and the
        // selector changes during line 2 of the third, which must still complete unchanged
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1; sel = 2'd3;
        recv_frame(-1);
        check_frame(3, 0, 0);
        recv_frame(-1);
        check("b2b_gap_f2", start_wait, 0);
        check_frame(3, 1, 0);
        recv_frame(2);
        check("b2b_gap_f3", start_wait, 0);
        check("enable_dropped", 32'(enable), 0);
        check_frame(3, 2, 1);
        @(negedge clk);
        check("idle_after_drop_vsync", 32'(vsync), 0);
        check("idle_after_drop_busy", 32'(busy), 0);

        // v-ramp frame; selector change mid-frame must not take effect
        enable = 1'b1; sel = 2'd1;
        recv_frame(0);
        check_frame(1, 3, 1);

        // 6: reset in the middle of an active line
        enable = 1'b1; sel = 2'd0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (hsync) break;
        end
        check("reached_active", 32'(hsync), 1);
        rst_n = 1'b0;
        #1;
        check("rst_outputs_zero", {fcnt, data, vsync, hsync, busy, fdone, pclk}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; sel = 2'd3;
        recv_frame(0);
        check_frame(3, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
